// File: rtl/mac_job_sched_if.sv
// Requester and engine handshake bundle for mac_job_sched.
// The slave side is the scheduler; the master side is the cores plus the engine.
interface mac_job_sched_if #(
  parameter int unsigned N_CORES = 2,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [N_CORES-1:0]        req_valid_i;
  logic [N_CORES-1:0]        req_ready_o;
  logic [N_CORES*DATA_W-1:0] req_data_i;
  logic                      start_o;
  logic [DATA_W-1:0]         job_data_o;
  logic [CW-1:0]             job_core_o;
  logic                      done_i;

  modport master (
    output req_valid_i, req_data_i, done_i,
    input  req_ready_o, start_o, job_data_o, job_core_o
  );

  modport slave (
    input  req_valid_i, req_data_i, done_i,
    output req_ready_o, start_o, job_data_o, job_core_o
  );
endinterface

// File: rtl/mac_job_sched.sv
// Multi-core job scheduler: round-robin intake into a job FIFO, one-at-a-time
// launch on the MAC engine, per-core completion events and an optional RUN watchdog.
module mac_job_sched #(
  parameter int unsigned N_CORES   = 2,
  parameter int unsigned N_CONTEXT = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  mac_job_sched_if.slave                 bus,
  output logic [N_CORES-1:0]             evt_o,
  output logic                           busy_o,
  output logic [$clog2(N_CONTEXT+1)-1:0] nb_pending_o,
  output logic                           err_o
);

  localparam int unsigned CW      = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned PW      = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
  localparam int unsigned NPW     = $clog2(N_CONTEXT + 1);
  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic [DATA_W-1:0] r_fifo_data [N_CONTEXT];
  logic [CW-1:0]     r_fifo_core [N_CONTEXT];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [NPW-1:0]    r_count;

  logic [CW-1:0]     r_rr_ptr;
  logic [TW-1:0]     r_wd_cnt;
  logic              r_start;
  logic              r_busy;
  logic              r_err;
  logic [N_CORES-1:0] r_evt;
  logic [DATA_W-1:0] r_job_data;
  logic [CW-1:0]     r_job_core;

  logic              w_flush;
  logic              w_can_accept;
  logic [N_CORES-1:0] w_grant;
  logic [CW-1:0]     w_grant_idx;
  logic              w_push;
  logic              w_pop;
  logic              w_launch;
  logic              w_run_done;
  logic              w_run_timeout;
  logic              w_spurious;
  logic [DATA_W-1:0] w_req_words [N_CORES];

  assign w_flush = rst_i | clear_i;

  for (genvar g = 0; g < N_CORES; g++) begin : g_words
    assign w_req_words[g] = bus.req_data_i[g*DATA_W +: DATA_W];
  end

  // Round-robin grant: first valid core at or after r_rr_ptr; a full FIFO admits nothing.
  always_comb begin : arb
    logic          found;
    logic [CW:0]   sum;
    logic [CW-1:0] idx;
    found        = 1'b0;
    sum          = '0;
    idx          = '0;
    w_grant      = '0;
    w_grant_idx  = '0;
    w_can_accept = (r_count < NPW'(N_CONTEXT)) && !w_flush;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      sum = {1'b0, r_rr_ptr} + (CW+1)'(i);
      if (sum >= (CW+1)'(N_CORES)) sum = sum - (CW+1)'(N_CORES);
      idx = sum[CW-1:0];
      if (!found && w_can_accept && bus.req_valid_i[idx]) begin
        found        = 1'b1;
        w_grant[idx] = 1'b1;
        w_grant_idx  = idx;
      end
    end
  end

  assign w_push = |w_grant;

  always_ff @(posedge clk_i) begin : state_reg
    if (w_flush) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state plus the per-cycle decisions the registered outputs are built from.
  always_comb begin : fsm_nxt
    w_state_nxt   = r_state;
    w_launch      = 1'b0;
    w_pop         = 1'b0;
    w_run_done    = 1'b0;
    w_run_timeout = 1'b0;
    w_spurious    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_spurious = bus.done_i;
        if (r_count != '0) begin
          w_state_nxt = S_START;
          w_launch    = 1'b1;
        end
      end
      S_START: begin
        w_spurious  = bus.done_i;
        w_pop       = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.done_i) begin
          w_run_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if ((TIMEOUT > 0) && (r_wd_cnt == TW'(TO_LAST))) begin
          w_run_timeout = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job FIFO; push and pop may coincide, leaving occupancy unchanged.
  always_ff @(posedge clk_i) begin : fifo
    if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_req_words[w_grant_idx];
        r_fifo_core[r_wr_ptr] <= w_grant_idx;
        r_wr_ptr <= (r_wr_ptr == PW'(N_CONTEXT - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(N_CONTEXT - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered engine-side outputs, completion events, RR pointer and watchdog.
  always_ff @(posedge clk_i) begin : outs
    if (w_flush) begin
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_evt      <= '0;
      r_job_data <= '0;
      r_job_core <= '0;
      r_rr_ptr   <= '0;
      r_wd_cnt   <= '0;
    end else begin
      r_start <= w_launch;
      r_evt   <= '0;
      if (w_push) begin
        r_rr_ptr <= (w_grant_idx == CW'(N_CORES - 1)) ? '0 : w_grant_idx + 1'b1;
      end
      if (w_launch) begin
        r_busy     <= 1'b1;
        r_job_data <= r_fifo_data[r_rd_ptr];
        r_job_core <= r_fifo_core[r_rd_ptr];
      end
      if (w_run_done || w_run_timeout) begin
        r_busy            <= 1'b0;
        r_evt[r_job_core] <= 1'b1;
      end
      if (r_state == S_RUN) r_wd_cnt <= r_wd_cnt + 1'b1;
      else                  r_wd_cnt <= '0;
    end
  end

  // Sticky error survives clear_i; only rst_i drops it.
  always_ff @(posedge clk_i) begin : err_reg
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (!clear_i && (w_spurious || w_run_timeout)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.req_ready_o = w_grant;
  assign bus.start_o     = r_start;
  assign bus.job_data_o  = r_job_data;
  assign bus.job_core_o  = r_job_core;
  assign evt_o           = r_evt;
  assign busy_o          = r_busy;
  assign nb_pending_o    = r_count;
  assign err_o           = r_err;

endmodule

// File: tb/tb_mac_job_sched.sv
// Self-checking bench for mac_job_sched: directed vector table, corner sequences,
// and randomized traffic checked against a queue-based scheduler model.
module tb_mac_job_sched;
  localparam int unsigned NC = 2;
  localparam int unsigned NX = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  localparam logic [31:0] Z    = 32'h0;
  localparam logic [31:0] CAFE = 32'hCAFE_0001;
  localparam logic [31:0] A0   = 32'hA000_0000;
  localparam logic [31:0] A1   = 32'hA000_0001;
  localparam logic [31:0] B0   = 32'hB000_0000;
  localparam logic [31:0] B1   = 32'hB000_0001;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [NC-1:0] evt;
  logic          busy;
  logic [1:0]    nb;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_job_sched_if #(.N_CORES(NC), .DATA_W(DW)) bus ();

  mac_job_sched #(.N_CORES(NC), .N_CONTEXT(NX), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .bus(bus),
    .evt_o(evt), .busy_o(busy), .nb_pending_o(nb), .err_o(err)
  );

  typedef struct {
    logic [1:0] valid; logic [31:0] d0; logic [31:0] d1; logic done;
    logic [1:0] rdy; logic st; logic bz; logic [1:0] nbv; logic [1:0] ev; logic er;
    logic [31:0] job; logic core;
  } vec_t;

  typedef struct packed { logic [31:0] data; logic [0:0] core; } job_t;

  function automatic vec_t r(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                             input logic dn, input logic [1:0] rdy, input logic st, input logic bz,
                             input logic [1:0] nbv, input logic [1:0] ev, input logic er,
                             input logic [31:0] job, input logic core);
    vec_t x;
    x.valid = v; x.d0 = d0; x.d1 = d1; x.done = dn; x.rdy = rdy; x.st = st; x.bz = bz;
    x.nbv = nbv; x.ev = ev; x.er = er; x.job = job; x.core = core;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input logic st, input logic bz, input logic [1:0] nbv,
                          input logic [1:0] ev, input logic er, input logic [31:0] job,
                          input logic core);
    chk({tag, " start"}, 32'(bus.start_o), 32'(st));
    chk({tag, " busy"},  32'(busy), 32'(bz));
    chk({tag, " nb"},    32'(nb), 32'(nbv));
    chk({tag, " evt"},   32'(evt), 32'(ev));
    chk({tag, " err"},   32'(err), 32'(er));
    chk({tag, " job"},   bus.job_data_o, job);
    chk({tag, " core"},  32'(bus.job_core_o), 32'(core));
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic dn, input logic cl);
    bus.req_valid_i = v;
    bus.req_data_i  = {d1, d0};
    bus.done_i      = dn;
    clr             = cl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, Z, Z, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t  tbl[$];
    job_t  q[$];
    job_t  cur;
    int    mode, nxt, age;
    int    rr;
    logic  m_err;
    logic [1:0] m_evt, exp_g;
    bit    pv[NC];
    logic [31:0] pd[NC];
    logic  dn, cl;

    // Reset with both cores requesting: everything, including grants, must stay 0.
    rst = 1'b1;
    drive(2'b11, A0, B0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", 32'(bus.req_ready_o), 32'h0);
    chk_regs("reset", 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, Z, 1'b0);
    rst = 1'b0;
    drive(2'b00, Z, Z, 1'b0, 1'b0);

    // Single job with done on the watchdog cycle, spurious done, RR alternation, full FIFO.
    tbl.push_back(r(2'b10, Z, CAFE, 1'b0, 2'b10, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, Z, 1'b0));
    tbl.push_back(r(2'b00, Z, Z, 1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 2'b00, 1'b0, Z, 1'b0));
    tbl.push_back(r(2'b00, Z, Z, 1'b0, 2'b00, 1'b1, 1'b1, 2'd1, 2'b00, 1'b0, CAFE, 1'b1));
    for (int i = 0; i < 7; i++)
      tbl.push_back(r(2'b00, Z, Z, 1'b0, 2'b00, 1'b0, 1'b1, 2'd0, 2'b00, 1'b0, CAFE, 1'b1));
    tbl.push_back(r(2'b00, Z, Z, 1'b1, 2'b00, 1'b0, 1'b1, 2'd0, 2'b00, 1'b0, CAFE, 1'b1));
    tbl.push_back(r(2'b00, Z, Z, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 2'b10, 1'b0, CAFE, 1'b1));
    tbl.push_back(r(2'b00, Z, Z, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, CAFE, 1'b1));
    tbl.push_back(r(2'b00, Z, Z, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 2'b00, 1'b1, CAFE, 1'b1));
    tbl.push_back(r(2'b11, A0, B0, 1'b0, 2'b01, 1'b0, 1'b0, 2'd0, 2'b00, 1'b1, CAFE, 1'b1));
    tbl.push_back(r(2'b11, A1, B0, 1'b0, 2'b10, 1'b0, 1'b0, 2'd1, 2'b00, 1'b1, CAFE, 1'b1));
    tbl.push_back(r(2'b11, A1, B1, 1'b0, 2'b00, 1'b1, 1'b1, 2'd2, 2'b00, 1'b1, A0, 1'b0));
    tbl.push_back(r(2'b11, A1, B1, 1'b0, 2'b01, 1'b0, 1'b1, 2'd1, 2'b00, 1'b1, A0, 1'b0));
    tbl.push_back(r(2'b10, Z, B1, 1'b0, 2'b00, 1'b0, 1'b1, 2'd2, 2'b00, 1'b1, A0, 1'b0));
    tbl.push_back(r(2'b10, Z, B1, 1'b1, 2'b00, 1'b0, 1'b1, 2'd2, 2'b00, 1'b1, A0, 1'b0));
    tbl.push_back(r(2'b10, Z, B1, 1'b0, 2'b00, 1'b0, 1'b0, 2'd2, 2'b01, 1'b1, A0, 1'b0));
    tbl.push_back(r(2'b10, Z, B1, 1'b0, 2'b00, 1'b1, 1'b1, 2'd2, 2'b00, 1'b1, B0, 1'b1));
    tbl.push_back(r(2'b10, Z, B1, 1'b0, 2'b10, 1'b0, 1'b1, 2'd1, 2'b00, 1'b1, B0, 1'b1));
    tbl.push_back(r(2'b00, Z, Z, 1'b1, 2'b00, 1'b0, 1'b1, 2'd2, 2'b00, 1'b1, B0, 1'b1));
    tbl.push_back(r(2'b00, Z, Z, 1'b0, 2'b00, 1'b0, 1'b0, 2'd2, 2'b10, 1'b1, B0, 1'b1));
    tbl.push_back(r(2'b00, Z, Z, 1'b0, 2'b00, 1'b1, 1'b1, 2'd2, 2'b00, 1'b1, A1, 1'b0));

    foreach (tbl[i]) begin
      @(negedge clk);
      chk_regs($sformatf("row%0d", i), tbl[i].st, tbl[i].bz, tbl[i].nbv, tbl[i].ev, tbl[i].er,
               tbl[i].job, tbl[i].core);
      drive(tbl[i].valid, tbl[i].d0, tbl[i].d1, tbl[i].done, 1'b0);
      #1;
      chk($sformatf("row%0d ready", i), 32'(bus.req_ready_o), 32'(tbl[i].rdy));
    end

    // Watchdog expiry, then the queued job launches; rst_i also drops err_o.
    do_reset();
    @(negedge clk);
    chk("wd reset err", 32'(err), 32'h0);
    drive(2'b01, 32'hD0D0_0000, Z, 1'b0, 1'b0);
    #1 chk("wd c0 ready", 32'(bus.req_ready_o), 32'h1);
    @(negedge clk);
    drive(2'b10, Z, 32'hD1D1_0001, 1'b0, 1'b0);
    #1 chk("wd c1 ready", 32'(bus.req_ready_o), 32'h2);
    @(negedge clk);
    drive(2'b00, Z, Z, 1'b0, 1'b0);
    chk_regs("wd c2", 1'b1, 1'b1, 2'd2, 2'b00, 1'b0, 32'hD0D0_0000, 1'b0);
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("wd c%0d evt", c), 32'(evt), 32'h0);
      chk($sformatf("wd c%0d err", c), 32'(err), 32'h0);
    end
    @(negedge clk);
    chk_regs("wd c11", 1'b0, 1'b0, 2'd1, 2'b01, 1'b1, 32'hD0D0_0000, 1'b0);
    @(negedge clk);
    chk_regs("wd c12", 1'b1, 1'b1, 2'd1, 2'b00, 1'b1, 32'hD1D1_0001, 1'b1);
    @(negedge clk);
    drive(2'b00, Z, Z, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'b00, Z, Z, 1'b0, 1'b0);
    chk_regs("wd c14", 1'b0, 1'b0, 2'd0, 2'b10, 1'b1, 32'hD1D1_0001, 1'b1);

    // clear_i mid-job: FIFO dropped, no event, later done_i flags an error.
    do_reset();
    @(negedge clk);
    drive(2'b01, 32'hE0E0_0000, Z, 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b10, Z, 32'hE1E1_0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(2'b00, Z, Z, 1'b0, 1'b0);
    chk_regs("clr c2", 1'b1, 1'b1, 2'd2, 2'b00, 1'b0, 32'hE0E0_0000, 1'b0);
    @(negedge clk);
    chk_regs("clr c3", 1'b0, 1'b1, 2'd1, 2'b00, 1'b0, 32'hE0E0_0000, 1'b0);
    @(negedge clk);
    drive(2'b00, Z, Z, 1'b0, 1'b1);
    @(negedge clk);
    drive(2'b00, Z, Z, 1'b0, 1'b0);
    chk_regs("clr c5", 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, Z, 1'b0);
    for (int c = 6; c <= 8; c++) begin
      @(negedge clk);
      chk_regs($sformatf("clr c%0d", c), 1'b0, 1'b0, 2'd0, 2'b00, 1'b0, Z, 1'b0);
    end
    @(negedge clk);
    drive(2'b00, Z, Z, 1'b1, 1'b0);
    @(negedge clk);
    drive(2'b00, Z, Z, 1'b0, 1'b0);
    chk_regs("clr c10", 1'b0, 1'b0, 2'd0, 2'b00, 1'b1, Z, 1'b0);

    // Randomized traffic against a queue model of the scheduling rules.
    for (int batch = 0; batch < 4; batch++) begin
      do_reset();
      q.delete(); cur = '0; mode = 0; age = 0; rr = 0; m_err = 1'b0; m_evt = '0;
      for (int c = 0; c < NC; c++) begin pv[c] = 1'b0; pd[c] = 32'h0; end
      for (int cyc = 0; cyc < 500; cyc++) begin
        @(negedge clk);
        chk_regs($sformatf("rnd b%0d c%0d", batch, cyc), mode == 1, mode != 0, 2'(q.size()),
                 m_evt, m_err, cur.data, cur.core);
        for (int c = 0; c < NC; c++)
          if (!pv[c] && $urandom_range(0, 2) == 0) begin pv[c] = 1'b1; pd[c] = $urandom; end
        dn = (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
        cl = ($urandom_range(0, 149) == 0);
        drive({pv[1], pv[0]}, pd[0], pd[1], dn, cl);
        exp_g = '0;
        if (!cl && q.size() < NX)
          for (int k = 0; k < NC; k++) begin
            int c;
            c = (rr + k) % NC;
            if (pv[c] && exp_g == '0) exp_g[c] = 1'b1;
          end
        #1;
        chk($sformatf("rnd b%0d c%0d ready", batch, cyc), 32'(bus.req_ready_o), 32'(exp_g));
        m_evt = '0;
        if (cl) begin
          q.delete(); cur = '0; mode = 0; age = 0; rr = 0;
        end else begin
          if (dn && mode != 2) m_err = 1'b1;
          nxt = mode;
          case (mode)
            0: if (q.size() > 0) begin nxt = 1; cur = q[0]; end
            1: begin void'(q.pop_front()); nxt = 2; age = 1; end
            default: begin
              if (dn) begin nxt = 0; m_evt[cur.core] = 1'b1; end
              else if (age == TO) begin nxt = 0; m_evt[cur.core] = 1'b1; m_err = 1'b1; end
              else age++;
            end
          endcase
          mode = nxt;
          for (int c = 0; c < NC; c++)
            if (exp_g[c]) begin
              job_t j;
              j.data = pd[c];
              j.core = 1'(c);
              q.push_back(j);
              pv[c] = 1'b0;
              rr = (c + 1) % NC;
            end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
